mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's data/instruction port.
- Accepts one request at a time over a four-phase req/ack handshake and serves it from an internal word array after a programmable number of wait states.
- Supports word and byte reads and writes. Byte writes are done internally as read-modify-write.
- Flags misaligned and out-of-range accesses instead of executing them.

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase req/ack handshake, programmable wait states,
// word/byte access with read-modify-write byte stores and error flagging.
module mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic        byte_or_word,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_MERGE, S_RESP} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic               bw_q, bw_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         lane_q, lane_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        merge_q, merge_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;

   logic [31:0]        mem [DEPTH_WORDS];
   logic               req_err;
   logic [31:0]        rd_word;
   logic [31:0]        merged;
   logic               mem_we;
   logic [31:0]        mem_wdata;

   assign req_err = (!byte_or_word && addr[1:0] != 2'b00) ||
                    ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
   assign rd_word = mem[idx_q];

   always_comb begin
      merged = merge_q;
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
   end

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (req_err)               state_d = S_RESP;
               else if (WAIT_CYCLES == 0) state_d = S_ACCESS;
               else                       state_d = S_WAIT;
            end
         end
         S_WAIT:   if (cnt_q == 4'd1) state_d = S_ACCESS;
         S_ACCESS: state_d = (wr_q && bw_q) ? S_MERGE : S_RESP;
         S_MERGE:  state_d = S_RESP;
         S_RESP:   if (!req) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy      = (state_q != S_IDLE);
      mem_we    = (state_q == S_ACCESS && wr_q && !bw_q) || (state_q == S_MERGE);
      mem_wdata = (state_q == S_MERGE) ? merged : wdata_q;
   end

   // Datapath next values
   always_comb begin
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      bw_d    = bw_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      merge_d = merge_q;
      ack_d   = ack_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               wr_d    = wr;
               bw_d    = byte_or_word;
               idx_d   = addr[IDX_W+1:2];
               lane_d  = addr[1:0];
               wdata_d = wdata;
               cnt_d   = 4'(WAIT_CYCLES);
               ack_d   = req_err;
               err_d   = req_err;
            end
         end
         S_WAIT: cnt_d = cnt_q - 4'd1;
         S_ACCESS: begin
            if (!wr_q) rdata_d = bw_q ? {24'b0, rd_word[{lane_q, 3'b000} +: 8]} : rd_word;
            if (wr_q && bw_q) merge_d = rd_word;
            else              ack_d   = 1'b1;
         end
         S_MERGE: ack_d = 1'b1;
         S_RESP: begin
            if (!req) begin
               ack_d = 1'b0;
               err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         bw_q    <= 1'b0;
         idx_q   <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         merge_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         bw_q    <= bw_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         merge_q <= merge_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the array has no reset; contents survive reset, and a reset forces IDLE so no write fires.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= mem_wdata;
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (1 and 0 wait states) driven with the same
// transactions, checked every cycle against a transaction-level timeline model.
module tb_mem_responder;

   localparam int DEPTH = 256;
   localparam int BIG   = 1 << 30;
   localparam int WC[2] = '{1, 0};

   logic        clk = 1'b0;
   logic        reset;
   logic        req, wr, bw;
   logic [31:0] addr, wdata;
   logic [31:0] rdata [2];
   logic        ack [2];
   logic        err [2];
   logic        busy [2];

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut0 (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .byte_or_word(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .byte_or_word(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: word array plus the timeline of the current transaction.
   bit [31:0]   m_mem [DEPTH];
   int          t_start = BIG;
   int          t_drop  = BIG;
   bit          t_err   = 1'b0;
   bit          t_bwr   = 1'b0;
   bit          rd_upd  = 1'b0;
   logic [31:0] rd_old  = '0;
   logic [31:0] rd_new  = '0;
   bit          chk_en  = 1'b0;

   function automatic int lat_of(input int wc);
      if (t_err) return 1;
      return wc + (t_bwr ? 3 : 2);
   endfunction

   always @(negedge clk) begin
      if (chk_en && reset) begin
         for (int d = 0; d < 2; d++) begin
            int          done;
            bit          b_e, a_e;
            logic [31:0] r_e;
            done = t_start + lat_of(WC[d]) - 1;
            b_e  = (cyc >= t_start) && (cyc < t_drop);
            a_e  = b_e && (cyc >= done);
            r_e  = (rd_upd && cyc >= done) ? rd_new : rd_old;
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(b_e));
            check($sformatf("ack%0d", d), 32'(ack[d]), 32'(a_e));
            check($sformatf("err%0d", d), 32'(err[d]), 32'(a_e && t_err));
            check($sformatf("rdata%0d", d), rdata[d], r_e);
         end
      end
   end

   task automatic do_txn(input bit w_i, input bit bw_i, input logic [31:0] a_i,
                         input logic [31:0] wd_i, input int hold,
                         output int l0, output int l1, output bit e0);
      bit e;
      int idx, lane;
      e    = (!bw_i && a_i[1:0] != 2'b00) || (a_i[31:2] >= DEPTH);
      idx  = int'(a_i[9:2]);
      lane = int'(a_i[1:0]);
      @(posedge clk); #1;
      rd_old = rd_upd ? rd_new : rd_old;
      t_err  = e;
      t_bwr  = !e && w_i && bw_i;
      rd_upd = !e && !w_i;
      if (!e) begin
         if (!w_i)      rd_new = bw_i ? ((m_mem[idx] >> (8 * lane)) & 32'hFF) : m_mem[idx];
         else if (bw_i) m_mem[idx][8*lane +: 8] = wd_i[7:0];
         else           m_mem[idx] = wd_i;
      end
      t_start = cyc + 1;
      t_drop  = BIG;
      req = 1'b1; wr = w_i; bw = bw_i; addr = a_i; wdata = wd_i;
      l0 = 0; l1 = 0; e0 = 1'b0;
      for (int k = 0; k < 40 && !(ack[0] && ack[1]); k++) begin
         @(posedge clk); #1;
         if (ack[0] && l0 == 0) begin
            l0 = cyc - t_start + 1;
            e0 = err[0];
         end
         if (ack[1] && l1 == 0) l1 = cyc - t_start + 1;
      end
      if (!(ack[0] && ack[1])) begin
         n_checks++;
         n_errors++;
         $display("FAIL ack_timeout: got ack0=%0b ack1=%0b expected both 1", ack[0], ack[1]);
      end
      repeat (hold) begin
         @(posedge clk); #1;
      end
      req    = 1'b0;
      t_drop = cyc + 1;
      @(posedge clk); #1;
   endtask

   initial begin
      int l0, l1;
      bit e0;
      req = 1'b0; wr = 1'b0; bw = 1'b0; addr = '0; wdata = '0;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
         check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
         check($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
      end
      @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;

      // Word write then read
      do_txn(1, 0, 32'h10, 32'hDEADBEEF, 0, l0, l1, e0);
      check("lat_wwrite0", l0, 3);
      check("lat_wwrite1", l1, 2);
      do_txn(0, 0, 32'h10, 32'h0, 0, l0, l1, e0);
      check("lat_wread0", l0, 3);
      check("lat_wread1", l1, 2);
      check("rd_beef", rdata[0], 32'hDEADBEEF);

      // Byte write merge and byte read
      do_txn(1, 1, 32'h11, 32'h000000A5, 1, l0, l1, e0);
      check("lat_bwrite0", l0, 4);
      check("lat_bwrite1", l1, 3);
      do_txn(0, 0, 32'h10, 32'h0, 0, l0, l1, e0);
      check("rd_merged", rdata[0], 32'hDEADA5EF);
      do_txn(0, 1, 32'h13, 32'h0, 0, l0, l1, e0);
      check("rd_byte3", rdata[1], 32'h000000DE);

      // Misaligned and out-of-range
      do_txn(0, 0, 32'h12, 32'h0, 0, l0, l1, e0);
      check("lat_misalign", l0, 1);
      check("err_misalign", 32'(e0), 32'd1);
      check("rd_kept", rdata[0], 32'h000000DE);
      do_txn(0, 0, 32'(DEPTH * 4), 32'h0, 0, l0, l1, e0);
      check("lat_range", l1, 1);
      check("err_range", 32'(e0), 32'd1);
      do_txn(0, 0, 32'h10, 32'h0, 0, l0, l1, e0);
      check("rd_after_err", rdata[0], 32'hDEADA5EF);

      // Reset in the middle of a word write
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b1; bw = 1'b0; addr = 32'h10; wdata = 32'h12345678;
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("mid_rst_ack%0d", d), 32'(ack[d]), 32'd0);
         check($sformatf("mid_rst_err%0d", d), 32'(err[d]), 32'd0);
         check($sformatf("mid_rst_busy%0d", d), 32'(busy[d]), 32'd0);
         check($sformatf("mid_rst_rdata%0d", d), rdata[d], 32'd0);
      end
      req = 1'b0;
      t_start = BIG; t_drop = BIG; rd_old = '0; rd_upd = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      do_txn(0, 0, 32'h10, 32'h0, 0, l0, l1, e0);
      check("rd_after_rst", rdata[0], 32'hDEADA5EF);

      // Long req hold after ack, then back-to-back write/read
      do_txn(1, 0, 32'h20, 32'hCAFEF00D, 5, l0, l1, e0);
      do_txn(0, 0, 32'h20, 32'h0, 0, l0, l1, e0);
      check("rd_cafe", rdata[1], 32'hCAFEF00D);

      // Initialise a window, then random traffic
      for (int i = 0; i < 32; i++)
         do_txn(1, 0, 32'(i * 4), $urandom, 0, l0, l1, e0);
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 6) == 0) begin
            a = $urandom;
            if (a[31:2] < DEPTH) a[31] = 1'b1;
         end else begin
            a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
         end
         do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 3), l0, l1, e0);
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
